// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the single-cycle CPU, including the
// request-stage state, halt causes and the word-alignment mask.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        DATA,
        HALTED
    } req_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_HALT = 2'd1,
        CAUSE_ADDR = 2'd2,
        CAUSE_OVF  = 2'd3
    } halt_cause_t;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    // Only the two low bits decide word alignment; no sign or width handling.
    function automatic logic is_misaligned(input word_t addr);
        return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running performance counter: increments when en is high and wraps
// modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is always written with non-blocking (<=) so every
    // flop samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/request_unit.sv
// Memory-request stage: sequences instruction fetch and the following data
// access via ihit/dhit, raises fatal halts and keeps performance counters.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic             halt,
    input  logic             ov_trap,
    input  word_t            alu_out,
    input  logic             alu_overflow,
    input  word_t            store_data,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output word_t            dmemaddr,
    output word_t            dmemstore,
    output logic             pc_en,
    output logic             halted,
    output logic [1:0]       cause,
    output word_t            badvaddr,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    req_state_t  state, next_state;
    halt_cause_t cause_q, next_cause;
    word_t       badvaddr_q, next_badvaddr;
    logic        lat_ren, lat_wen;
    logic        latch_en;
    logic        stall_inc;
    logic        mem_req;

    assign mem_req = dREN | dWEN;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state    = state;
        next_cause    = cause_q;
        next_badvaddr = badvaddr_q;
        latch_en      = 1'b0;
        stall_inc     = 1'b0;
        pc_en         = 1'b0;
        unique case (state)
            FETCH: begin
                if (ihit) begin
                    if (mem_req && is_misaligned(alu_out)) begin
                        next_state    = HALTED;
                        next_cause    = CAUSE_ADDR;
                        next_badvaddr = alu_out;
                    end else if (ov_trap && alu_overflow) begin
                        next_state = HALTED;
                        next_cause = CAUSE_OVF;
                    end else if (halt) begin
                        next_state = HALTED;
                        next_cause = CAUSE_HALT;
                    end else if (mem_req) begin
                        latch_en   = 1'b1;
                        next_state = DATA;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            DATA: begin
                if (dhit) begin
                    pc_en      = 1'b1;
                    next_state = FETCH;
                end else begin
                    stall_inc = 1'b1;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            cause_q    <= CAUSE_NONE;
            badvaddr_q <= '0;
        end else begin
            state      <= next_state;
            cause_q    <= next_cause;
            badvaddr_q <= next_badvaddr;
        end
    end

    // NOTE: address/store registers are reset only because they are visible
    // outputs with defined reset values; pure data storage would not need it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dmemaddr  <= '0;
            dmemstore <= '0;
            lat_ren   <= 1'b0;
            lat_wen   <= 1'b0;
        end else if (latch_en) begin
            dmemaddr  <= alu_out;
            dmemstore <= store_data;
            lat_ren   <= dREN;
            lat_wen   <= dWEN;
        end
    end

    // Requests decode from the state register, so an async reset drops them at once.
    assign imemREN  = (state == FETCH);
    assign dmemREN  = (state == DATA) && lat_ren && !lat_wen;
    assign dmemWEN  = (state == DATA) && lat_wen;
    assign halted   = (state == HALTED);
    assign cause    = cause_q;
    assign badvaddr = badvaddr_q;

    perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (pc_en),
        .count (instr_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (stall_inc),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_request_unit.sv
// Bench for request_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_request_unit;
    import cpu_types_pkg::*;

    localparam int CNT_W = 32;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             ihit, dhit, dREN, dWEN, halt, ov_trap, alu_overflow;
    word_t            alu_out, store_data;
    logic             imemREN, dmemREN, dmemWEN, pc_en, halted;
    word_t            dmemaddr, dmemstore, badvaddr;
    logic [1:0]       cause;
    logic [CNT_W-1:0] instr_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    request_unit #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
        .halt(halt), .ov_trap(ov_trap), .alu_out(alu_out), .alu_overflow(alu_overflow),
        .store_data(store_data), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .pc_en(pc_en), .halted(halted),
        .cause(cause), .badvaddr(badvaddr), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one instruction at a time ----------------
    bit          m_stopped = 0;   // a fault or HALT has ended execution
    bit          m_in_mem = 0;    // waiting for the data cache
    bit          m_is_store = 0;
    word_t       m_addr = '0, m_data = '0, m_bad = '0;
    logic [1:0]  m_cause = 2'd0;
    logic [31:0] m_instr = 0, m_stall = 0;

    function automatic bit misaligned(input word_t a);
        return (a % 4) != 0;
    endfunction

    // What the current instruction does in its fetch cycle (0 retire, 1 memory, 2 stop).
    function automatic int fetch_outcome();
        if ((dREN || dWEN) && misaligned(alu_out)) return 2;
        if (ov_trap && alu_overflow) return 2;
        if (halt) return 2;
        if (dREN || dWEN) return 1;
        return 0;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_stopped = 0; m_in_mem = 0; m_is_store = 0;
            m_addr = '0; m_data = '0; m_bad = '0; m_cause = 2'd0;
            m_instr = 0; m_stall = 0;
        end else if (!m_stopped) begin
            if (m_in_mem) begin
                if (dhit) begin
                    m_in_mem = 0;
                    m_instr  = m_instr + 1;
                end else begin
                    m_stall = m_stall + 1;
                end
            end else if (ihit) begin
                if ((dREN || dWEN) && misaligned(alu_out)) begin
                    m_stopped = 1; m_cause = 2'd2; m_bad = alu_out;
                end else if (ov_trap && alu_overflow) begin
                    m_stopped = 1; m_cause = 2'd3;
                end else if (halt) begin
                    m_stopped = 1; m_cause = 2'd1;
                end else if (dREN || dWEN) begin
                    m_in_mem = 1; m_is_store = dWEN; m_addr = alu_out; m_data = store_data;
                end else begin
                    m_instr = m_instr + 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (nRST && cmp_en) begin
            logic e_pc;
            if (m_stopped)     e_pc = 1'b0;
            else if (m_in_mem) e_pc = dhit;
            else               e_pc = ihit && (fetch_outcome() == 0);
            check("m_pc_en",     pc_en,     e_pc);
            check("m_imemREN",   imemREN,   !m_stopped && !m_in_mem);
            check("m_dmemREN",   dmemREN,   m_in_mem && !m_is_store);
            check("m_dmemWEN",   dmemWEN,   m_in_mem && m_is_store);
            check("m_dmemaddr",  dmemaddr,  m_addr);
            check("m_dmemstore", dmemstore, m_data);
            check("m_halted",    halted,    m_stopped);
            check("m_cause",     cause,     m_cause);
            check("m_badvaddr",  badvaddr,  m_bad);
            check("m_instr_cnt", instr_cnt, m_instr);
            check("m_stall_cnt", stall_cnt, m_stall);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic i_h, input logic d_h, input logic r, input logic w,
                         input logic h, input logic ot, input logic of,
                         input word_t a, input word_t sd);
        ihit = i_h; dhit = d_h; dREN = r; dWEN = w; halt = h;
        ov_trap = ot; alu_overflow = of; alu_out = a; store_data = sd;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_pulse();
        drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
        nRST = 1'b0;
        @(posedge CLK);
        #2;
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        int stopped_cycles;
        drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
        #12;
        check("rst_imemREN", imemREN, 1);
        check("rst_dmemREN", dmemREN, 0);
        check("rst_dmemWEN", dmemWEN, 0);
        check("rst_halted", halted, 0);
        check("rst_cause", cause, 0);
        check("rst_counters", instr_cnt | stall_cnt, 0);
        nRST = 1'b1;
        cmp_en = 1'b1;
        tick();

        // ALU ops retire in their ihit cycle.
        drive(1, 0, 0, 0, 0, 0, 0, 32'h5, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 check("alu_pc_en", pc_en, 1);
            check("alu_imemREN", imemREN, 1);
            tick();
        end
        check("alu_instr_cnt", instr_cnt, 3);

        // Load with three stalls.
        drive(1, 0, 1, 0, 0, 0, 0, 32'h100, 32'h0);
        #1 check("ld_issue_pc_en", pc_en, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("ld_dmemREN", dmemREN, 1);
            check("ld_dmemaddr", dmemaddr, 32'h100);
            check("ld_stall_pc_en", pc_en, 0);
            tick();
        end
        dhit = 1;
        #1 check("ld_hit_dmemREN", dmemREN, 1);
        check("ld_hit_pc_en", pc_en, 1);
        tick();
        dhit = 0;
        check("ld_stall_cnt", stall_cnt, 3);
        check("ld_back_fetch", imemREN, 1);
        check("ld_done_dmemREN", dmemREN, 0);
        check("ld_instr_cnt", instr_cnt, 4);

        // Store with an immediate dhit.
        drive(1, 0, 0, 1, 0, 0, 0, 32'h204, 32'hDEAD_BEEF);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        #1 check("st_dmemWEN", dmemWEN, 1);
        check("st_dmemREN", dmemREN, 0);
        check("st_dmemstore", dmemstore, 32'hDEAD_BEEF);
        check("st_dmemaddr", dmemaddr, 32'h204);
        check("st_pc_en", pc_en, 1);
        tick();
        check("st_instr_cnt", instr_cnt, 5);

        // Overflow outranks HALT.
        drive(1, 0, 0, 0, 1, 1, 1, 32'h0, 32'h0);
        #1 check("ovf_pc_en", pc_en, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("ovf_cause", cause, 3);
        check("ovf_halted", halted, 1);
        reset_pulse();

        // HALT alone.
        drive(1, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        tick();
        check("halt_cause", cause, 1);
        check("halt_imemREN", imemREN, 0);
        check("halt_badvaddr", badvaddr, 0);
        reset_pulse();

        // Misaligned load, then later traffic must have no effect.
        drive(1, 0, 1, 0, 0, 0, 0, 32'h102, 32'h0);
        #1 check("mis_pc_en", pc_en, 0);
        tick();
        check("mis_dmemREN", dmemREN, 0);
        check("mis_cause", cause, 2);
        check("mis_badvaddr", badvaddr, 32'h102);
        drive(1, 1, 1, 0, 0, 0, 0, 32'h400, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 check("mis_frozen_pc_en", pc_en, 0);
            check("mis_frozen_dmemREN", dmemREN, 0);
            check("mis_frozen_badvaddr", badvaddr, 32'h102);
            tick();
        end
        reset_pulse();

        // Reset in the middle of a stalled store.
        drive(1, 0, 0, 1, 0, 0, 0, 32'h300, 32'h1234_5678);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("mid_dmemWEN", dmemWEN, 1);
        tick();
        #1 nRST = 1'b0;
        #1 check("mid_rst_dmemWEN", dmemWEN, 0);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_instr_cnt", instr_cnt, 0);
        @(posedge CLK);
        #2 nRST = 1'b1;
        #1 check("mid_rst_imemREN", imemREN, 1);
        tick();

        // Randomized traffic; recover from stops with a reset.
        stopped_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            logic mem;
            word_t a;
            mem = ($urandom % 3) == 0;
            a = $urandom & 32'hFFFF_FFFC;
            if (($urandom % 10) == 0) a[1:0] = 2'($urandom_range(1, 3));
            drive(($urandom % 4) != 0, ($urandom % 3) == 0,
                  mem && ($urandom % 2 == 0), mem && ($urandom % 3 != 0),
                  ($urandom % 50) == 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
                  a, $urandom);
            if (mem && !dREN && !dWEN) dREN = 1'b1;
            tick();
            stopped_cycles = m_stopped ? stopped_cycles + 1 : 0;
            if (stopped_cycles > 3) begin
                reset_pulse();
                stopped_cycles = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
